puf_key_sequencer: RTL and testbench
====================================

# puf_key_sequencer

Challenge sequencer and response collector directly upstream/downstream of the 16-bit RO-PUF stage. On a `start` request it issues NUM_RESP challenges from an internal LFSR, drives the PUF's `challenge`/`activation`/`generated` inputs, and waits for each `puf_ready`. It captures each `puf_response`, then releases the PUF and waits for `puf_ready` to clear. The collected responses are packed into a wide key register with a valid/error status for the key-derivation logic.

## Interface
Parameters:
- NUM_RESP, 4, responses per key (1..8)
- TIMEOUT, 16'd50000, max cycles spent in WAIT_READY or RELEASE before abort
- LFSR_SEED, 16'hACE1, reset seed and substitute for a zero seed

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset; one clock, sampled on rising edge of clk
- start  in  1  request a key; sampled only in IDLE
- seed_load  in  1  load `seed` into LFSR; honoured only in IDLE, priority over start
- seed  in  16  LFSR seed value
- challenge  out  16  challenge to PUF
- activation  out  4  PUF activation, constant 4'b0011 (both ROs)
- generated  out  1  PUF measurement request
- puf_response  in  16  PUF response
- puf_ready  in  1  PUF response valid; held while generated=1
- key  out  16*NUM_RESP  packed responses; response k at key[16k +: 16]
- key_valid  out  1  key complete; held until next accepted start
- busy  out  1  high in any state other than IDLE/DONE
- timeout_err  out  1  last request aborted; held until next accepted start
- weak_cnt  out  4  count of zero responses in current key

## Operation
- FSM states: IDLE, SETUP, WAIT_READY, RELEASE, DONE.
- IDLE:
  - seed_load=1 → lfsr <= (seed==0 ? LFSR_SEED : seed); stay in IDLE.
  - Else start=1 → clear key, key_valid, timeout_err, weak_cnt, idx; go to SETUP.
- SETUP (1 cycle): challenge <= lfsr, generated stays 0, so challenge is stable one cycle before the request. Go to WAIT_READY.
- WAIT_READY: generated=1.
  - On puf_ready=1: key[16*idx +: 16] <= puf_response; weak_cnt += (puf_response==0), saturating at 15; lfsr advances one step; generated <= 0; go to RELEASE.
- RELEASE: generated=0; wait for puf_ready=0.
  - Then if idx==NUM_RESP-1 → DONE with key_valid <= 1.
  - Else idx+1 → SETUP.
- DONE: one cycle, then IDLE. key and key_valid remain held.
- LFSR: 16-bit Galois, right shift, XOR 16'hB400 when shifted-out LSB=1. It is never zero. Its value persists across requests.
- challenge holds its value from SETUP through RELEASE.
- Timeout: 16-bit wait counter is cleared on entry to WAIT_READY and RELEASE and increments each cycle in those states.
  - Counter reaching TIMEOUT → timeout_err <= 1, generated <= 0, key_valid stays 0, go to IDLE without waiting for puf_ready low.
- start is ignored while busy. start and seed_load together in IDLE → seed load only.

## Timing
- Reset values: challenge=0, activation=4'b0011, generated=0, key=0, key_valid=0, busy=0, timeout_err=0, weak_cnt=0, lfsr=LFSR_SEED, state=IDLE.
- All outputs are registered.
- Reset mid-operation returns to IDLE next edge and drops generated immediately at that edge. The partial key is discarded.
- Cycle 0 start sampled → cycle 1 SETUP → cycle 2 generated=1.
- Capture edge is the first edge with puf_ready=1 in WAIT_READY; generated=0 from the next cycle.
- Per-response latency = 2 + PUF ready latency + release wait cycles.
- key_valid rises the cycle after the final RELEASE exit (in DONE) and busy falls in the same cycle.

## Test plan
- Bench PUF model (ready 3 cycles after generated, response = challenge ^ 16'h5A5A, ready clears 1 cycle after generated falls), reset seed, NUM_RESP=4, start → challenges 16'hACE1 then 16'hE270; key[15:0]=16'hF6BB, key[31:16]=16'hB82A; key_valid=1, timeout_err=0.
- seed_load with seed=0 then start → first challenge 16'hACE1. seed_load with seed=16'h1234 → first challenge 16'h1234.
- PUF model never asserts ready, TIMEOUT=20 → generated drops after 20 cycles in WAIT_READY; timeout_err=1, key_valid=0, busy=0.
- PUF model returns 0 for every challenge → key=0, weak_cnt=4, key_valid=1.
- rst_n low during the third WAIT_READY → next cycle generated=0, key=0, key_valid=0, lfsr=16'hACE1. A subsequent start works normally.
- start pulsed repeatedly while busy → exactly one key produced. Holding puf_ready high 5 extra cycles after capture → sequencer stays in RELEASE and issues no new SETUP until ready clears.

Source files
------------

// File: rtl/puf_key_sequencer_if.sv
// rtl/puf_key_sequencer_if.sv - handshake bundle between the key sequencer and the RO-PUF stage
//
// Signals:
//   challenge    16  challenge word presented to the PUF
//   activation    4  ring-oscillator enable mask
//   generated     1  measurement request
//   puf_response 16  measured response word
//   puf_ready     1  response valid, held while generated is high
// Modports:
//   master - sequencer side (drives challenge/activation/generated)
//   slave  - PUF side (drives puf_response/puf_ready)
interface puf_key_sequencer_if;
    logic [15:0] challenge;
    logic [3:0]  activation;
    logic        generated;
    logic [15:0] puf_response;
    logic        puf_ready;

    modport master (
        output challenge,
        output activation,
        output generated,
        input  puf_response,
        input  puf_ready
    );

    modport slave (
        input  challenge,
        input  activation,
        input  generated,
        output puf_response,
        output puf_ready
    );
endinterface

// File: rtl/puf_key_sequencer.sv
// rtl/puf_key_sequencer.sv - challenge sequencer and response collector for the 16-bit RO-PUF
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   start        in   request a key (IDLE only)
//   seed_load    in   load seed into LFSR (IDLE only, wins over start)
//   seed         in   LFSR seed value (zero maps to LFSR_SEED)
//   puf          if   master side of the PUF handshake bundle
//   key          out  packed responses, response k at key[16k +: 16]
//   key_valid    out  key complete, held until next accepted start
//   busy         out  high outside IDLE/DONE
//   timeout_err  out  last request aborted, held until next accepted start
//   weak_cnt     out  number of all-zero responses in the current key
module puf_key_sequencer #(
    parameter int          NUM_RESP  = 4,
    parameter logic [15:0] TIMEOUT   = 16'd50000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     seed_load,
    input  logic [15:0]              seed,
    puf_key_sequencer_if.master      puf,
    output logic [16*NUM_RESP-1:0]   key,
    output logic                     key_valid,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [3:0]               weak_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_RELEASE    = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_RESP - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_lfsr;
    logic [15:0]             r_challenge;
    logic [3:0]              r_activation;
    logic                    r_generated;
    logic [16*NUM_RESP-1:0]  r_key;
    logic                    r_key_valid;
    logic                    r_busy;
    logic                    r_timeout_err;
    logic [3:0]              r_weak_cnt;
    logic [2:0]              r_idx;
    logic [15:0]             r_wait_cnt;

    logic [15:0]             w_lfsr_step;
    logic [6:0]              w_slot;
    logic                    w_to_hit;
    logic                    w_last;
    logic                    w_generated_nxt;
    logic                    w_busy_nxt;

    // Galois right-shift step; taps 16'hB400 keep the register out of the zero state.
    assign w_lfsr_step = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ 16'hB400)
                                   : {1'b0, r_lfsr[15:1]};
    assign w_slot      = {r_idx, 4'b0000};
    // Counter started at 0 on entry, so the TIMEOUT-th cycle in the state is the last one.
    assign w_to_hit    = (r_wait_cnt == TIMEOUT - 16'd1);
    assign w_last      = (r_idx == LAST_IDX);

    // State register and datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_challenge   <= 16'h0000;
            r_activation  <= 4'b0011;
            r_generated   <= 1'b0;
            r_key         <= '0;
            r_key_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_weak_cnt    <= 4'd0;
            r_idx         <= 3'd0;
            r_wait_cnt    <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_activation <= 4'b0011;
            r_generated  <= w_generated_nxt;
            r_busy       <= w_busy_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (seed_load) begin
                        r_lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
                    end else if (start) begin
                        r_key         <= '0;
                        r_key_valid   <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_weak_cnt    <= 4'd0;
                        r_idx         <= 3'd0;
                    end
                end
                ST_SETUP: begin
                    r_challenge <= r_lfsr;
                    r_wait_cnt  <= 16'd0;
                end
                ST_WAIT_READY: begin
                    if (puf.puf_ready) begin
                        r_key[w_slot +: 16] <= puf.puf_response;
                        if (puf.puf_response == 16'h0000 && r_weak_cnt != 4'd15) begin
                            r_weak_cnt <= r_weak_cnt + 4'd1;
                        end
                        r_lfsr     <= w_lfsr_step;
                        r_wait_cnt <= 16'd0;
                    end else if (w_to_hit) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!puf.puf_ready) begin
                        if (w_last) begin
                            r_key_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else if (w_to_hit) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!seed_load && start) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: w_state_nxt = ST_WAIT_READY;
            ST_WAIT_READY: begin
                if (puf.puf_ready)  w_state_nxt = ST_RELEASE;
                else if (w_to_hit)  w_state_nxt = ST_IDLE;
            end
            ST_RELEASE: begin
                if (!puf.puf_ready) w_state_nxt = w_last ? ST_DONE : ST_SETUP;
                else if (w_to_hit)  w_state_nxt = ST_IDLE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state they describe.
    always_comb begin
        w_generated_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            ST_SETUP:      w_busy_nxt = 1'b1;
            ST_WAIT_READY: begin
                w_busy_nxt      = 1'b1;
                w_generated_nxt = 1'b1;
            end
            ST_RELEASE:    w_busy_nxt = 1'b1;
            default: ;
        endcase
    end

    assign puf.challenge  = r_challenge;
    assign puf.activation = r_activation;
    assign puf.generated  = r_generated;
    assign key            = r_key;
    assign key_valid      = r_key_valid;
    assign busy           = r_busy;
    assign timeout_err    = r_timeout_err;
    assign weak_cnt       = r_weak_cnt;

endmodule

// File: tb/tb_puf_key_sequencer.sv
// tb/tb_puf_key_sequencer.sv - directed self-checking bench for puf_key_sequencer
module tb_puf_key_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        seed_load;
    logic [15:0] seed;
    logic [63:0] key;
    logic        key_valid;
    logic        busy;
    logic        timeout_err;
    logic [3:0]  weak_cnt;

    int n_cmp;
    int n_err;

    // PUF model controls and observations
    logic        never_ready;
    logic        zero_resp;
    int          extra_hold;
    int          gcnt;
    int          hcnt;
    logic [15:0] chal_log [8];
    int          chal_n;
    int          viol;
    logic        prev_gen;
    int          kv_rises;
    logic        prev_kv;
    int          basic_cyc;

    puf_key_sequencer_if u_if ();

    puf_key_sequencer #(
        .NUM_RESP  (4),
        .TIMEOUT   (16'd20),
        .LFSR_SEED (16'hACE1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .seed_load   (seed_load),
        .seed        (seed),
        .puf         (u_if),
        .key         (key),
        .key_valid   (key_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .weak_cnt    (weak_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF model: ready three cycles into generated, response = challenge ^ 5A5A,
    // ready clears one cycle (plus extra_hold) after generated falls.
    always @(negedge clk) begin
        if (u_if.generated && !prev_gen && u_if.puf_ready) viol++;
        if (key_valid && !prev_kv) kv_rises++;
        prev_gen = u_if.generated;
        prev_kv  = key_valid;
        if (!rst_n) begin
            u_if.puf_ready    = 1'b0;
            u_if.puf_response = 16'h0000;
            gcnt = 0;
            hcnt = 0;
        end else if (u_if.generated) begin
            hcnt = 0;
            if (!never_ready) begin
                gcnt++;
                if (gcnt >= 3 && !u_if.puf_ready) begin
                    u_if.puf_ready    = 1'b1;
                    u_if.puf_response = zero_resp ? 16'h0000 : (u_if.challenge ^ 16'h5A5A);
                    if (chal_n < 8) chal_log[chal_n] = u_if.challenge;
                    chal_n++;
                end
            end
        end else begin
            gcnt = 0;
            if (u_if.puf_ready) begin
                if (hcnt >= extra_hold) u_if.puf_ready = 1'b0;
                else hcnt++;
            end
        end
    end

    task automatic do_seed_load(input logic [15:0] v);
        seed      = v;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < max) begin
            if (key_valid || timeout_err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (u_if.challenge !== 16'h0000) begin n_err++; $display("FAIL reset_challenge got %h exp 0000", u_if.challenge); end
        n_cmp++; if (u_if.activation !== 4'b0011) begin n_err++; $display("FAIL reset_activation got %b exp 0011", u_if.activation); end
        n_cmp++; if (u_if.generated !== 1'b0) begin n_err++; $display("FAIL reset_generated got %b exp 0", u_if.generated); end
        n_cmp++; if (key !== 64'h0) begin n_err++; $display("FAIL reset_key got %h exp 0", key); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid got %b exp 0", key_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
        n_cmp++; if (weak_cnt !== 4'd0) begin n_err++; $display("FAIL reset_weak_cnt got %0d exp 0", weak_cnt); end
    endtask

    task automatic test_basic;
        bit ok;
        int cyc;
        chal_n = 0;
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || u_if.generated !== 1'b0) begin n_err++; $display("FAIL basic_setup busy/gen got %b%b exp 10", busy, u_if.generated); end
        @(negedge clk);
        n_cmp++; if (u_if.generated !== 1'b1) begin n_err++; $display("FAIL basic_gen_cycle2 got %b exp 1", u_if.generated); end
        n_cmp++; if (u_if.challenge !== 16'hACE1) begin n_err++; $display("FAIL basic_challenge0 got %h exp ACE1", u_if.challenge); end
        wait_done(200, ok, cyc);
        basic_cyc = cyc;
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done_timeout got 0 exp 1"); end
        n_cmp++; if (chal_log[1] !== 16'hE270) begin n_err++; $display("FAIL basic_challenge1 got %h exp E270", chal_log[1]); end
        n_cmp++; if (key[15:0] !== 16'hF6BB) begin n_err++; $display("FAIL basic_key0 got %h exp F6BB", key[15:0]); end
        n_cmp++; if (key[31:16] !== 16'hB82A) begin n_err++; $display("FAIL basic_key1 got %h exp B82A", key[31:16]); end
        n_cmp++; if (key[47:32] !== 16'h2B62) begin n_err++; $display("FAIL basic_key2 got %h exp 2B62", key[47:32]); end
        n_cmp++; if (key[63:48] !== 16'h62C6) begin n_err++; $display("FAIL basic_key3 got %h exp 62C6", key[63:48]); end
        n_cmp++; if (key_valid !== 1'b1 || timeout_err !== 1'b0) begin n_err++; $display("FAIL basic_status kv/te got %b%b exp 10", key_valid, timeout_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got %b exp 0", busy); end
        n_cmp++; if (weak_cnt !== 4'd0) begin n_err++; $display("FAIL basic_weak got %0d exp 0", weak_cnt); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_seed;
        bit ok;
        int cyc;
        do_seed_load(16'h0000);
        chal_n = 0;
        pulse_start();
        wait_done(200, ok, cyc);
        n_cmp++; if (chal_log[0] !== 16'hACE1) begin n_err++; $display("FAIL seed_zero_chal got %h exp ACE1", chal_log[0]); end
        repeat (2) @(negedge clk);
        seed = 16'h1234; seed_load = 1'b1; start = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL seed_priority_busy got %b exp 0", busy); end
        chal_n = 0;
        pulse_start();
        wait_done(200, ok, cyc);
        n_cmp++; if (chal_log[0] !== 16'h1234) begin n_err++; $display("FAIL seed_1234_chal0 got %h exp 1234", chal_log[0]); end
        n_cmp++; if (chal_log[1] !== 16'h091A) begin n_err++; $display("FAIL seed_1234_chal1 got %h exp 091A", chal_log[1]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        int w;
        never_ready = 1'b1;
        pulse_start();
        w = 0;
        while (!u_if.generated && w < 10) begin @(negedge clk); w++; end
        n = 0;
        while (u_if.generated && n < 100) begin n++; @(negedge clk); end
        n_cmp++; if (n !== 20) begin n_err++; $display("FAIL timeout_gen_cycles got %0d exp 20", n); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_err got %b exp 1", timeout_err); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL timeout_key_valid got %b exp 0", key_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy got %b exp 0", busy); end
        never_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_resp;
        bit ok;
        int cyc;
        zero_resp = 1'b1;
        pulse_start();
        wait_done(200, ok, cyc);
        n_cmp++; if (key !== 64'h0) begin n_err++; $display("FAIL zero_key got %h exp 0", key); end
        n_cmp++; if (weak_cnt !== 4'd4) begin n_err++; $display("FAIL zero_weak got %0d exp 4", weak_cnt); end
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL zero_key_valid got %b exp 1", key_valid); end
        zero_resp = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int cyc;
        int rises;
        logic pg;
        pulse_start();
        rises = 0;
        pg = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (u_if.generated && !pg) rises++;
            pg = u_if.generated;
            if (rises == 3) break;
            @(negedge clk);
        end
        n_cmp++; if (rises !== 3 || key[31:0] === 32'h0) begin n_err++; $display("FAIL midrst_reach got rises=%0d key=%h exp 3 nonzero", rises, key[31:0]); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (u_if.generated !== 1'b0) begin n_err++; $display("FAIL midrst_gen got %b exp 0", u_if.generated); end
        n_cmp++; if (key !== 64'h0) begin n_err++; $display("FAIL midrst_key got %h exp 0", key); end
        n_cmp++; if (key_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_status kv/busy got %b%b exp 00", key_valid, busy); end
        @(negedge clk);
        chal_n = 0;
        pulse_start();
        wait_done(200, ok, cyc);
        n_cmp++; if (chal_log[0] !== 16'hACE1) begin n_err++; $display("FAIL midrst_lfsr got %h exp ACE1", chal_log[0]); end
        n_cmp++; if (key[15:0] !== 16'hF6BB || key_valid !== 1'b1) begin n_err++; $display("FAIL midrst_rerun got %h/%b exp F6BB/1", key[15:0], key_valid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        do_seed_load(16'hACE1);
        kv_rises = 0;
        start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
            start = (i % 2 == 0);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (kv_rises !== 1) begin n_err++; $display("FAIL b2b_keys got %0d exp 1", kv_rises); end
        n_cmp++; if (busy !== 1'b0 || key_valid !== 1'b1) begin n_err++; $display("FAIL b2b_status busy/kv got %b%b exp 01", busy, key_valid); end
        n_cmp++; if (key[15:0] !== 16'hF6BB || key[63:48] !== 16'h62C6) begin n_err++; $display("FAIL b2b_key got %h exp 62C6....F6BB", key); end
    endtask

    task automatic test_hold_ready;
        bit ok;
        int cyc;
        extra_hold = 5;
        do_seed_load(16'hACE1);
        viol = 0;
        pulse_start();
        wait_done(400, ok, cyc);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL hold_done_timeout got 0 exp 1"); end
        n_cmp++; if (viol !== 0) begin n_err++; $display("FAIL hold_early_setup got %0d exp 0", viol); end
        n_cmp++; if (cyc - (basic_cyc + 1) !== 20) begin n_err++; $display("FAIL hold_extra_latency got %0d exp 20", cyc - (basic_cyc + 1)); end
        n_cmp++; if (key[31:16] !== 16'hB82A || key[63:48] !== 16'h62C6) begin n_err++; $display("FAIL hold_key got %h exp 62C6..B82A....", key); end
        n_cmp++; if (timeout_err !== 1'b0 || key_valid !== 1'b1) begin n_err++; $display("FAIL hold_status te/kv got %b%b exp 01", timeout_err, key_valid); end
        extra_hold = 0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed = 16'h0000;
        never_ready = 1'b0; zero_resp = 1'b0; extra_hold = 0;
        gcnt = 0; hcnt = 0; chal_n = 0; viol = 0; prev_gen = 1'b0;
        kv_rises = 0; prev_kv = 1'b0; basic_cyc = 0;
        for (int i = 0; i < 8; i++) chal_log[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_seed();
        test_timeout();
        test_zero_resp();
        test_reset_mid();
        test_back_to_back();
        test_hold_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
